// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX framer and RX checker.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN        = 1'b0;
  localparam logic PAR_ODD         = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator, shared by the TX framer and the RX checker.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even mode: XOR of the data bits; odd mode: its inverse.
  always_comb begin
    par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// Bit period is Prescale clocks (0 behaves as 1). Define UART_TX_TWO_STOP_EN
// to emit two stop bits instead of one.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low) for one period
// DATA   | data[idx] for one period per bit, LSB first
// PARITY | computed parity bit for one period
// STOP   | stop bit(s), line high
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [CNT_WIDTH-1:0]  Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  uart_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  pm1_q, pm1_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;
  logic                  period_end;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q, stop2_d;
`endif

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  // The period limit is stored as P-1 so a Prescale of 0 collapses to a 1-clock bit.
  assign period_end = (cnt_q == pm1_q);

  // Next-state, counter, latch and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pm1_d     = pm1_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = UART_IDLE_LEVEL;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = period_end ? '0 : (cnt_q + CNT_ONE);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d = 1'b0;
`endif
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          pm1_d     = (Prescale == '0) ? '0 : (Prescale - CNT_ONE);
          state_d   = START;
        end
      end
      START: begin
        if (period_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      PARITY: begin
        if (period_end) state_d = STOP;
      end
      STOP: begin
        if (period_end) begin
`ifdef UART_TX_TWO_STOP_EN
          if (stop2_q) state_d = IDLE;
          else         stop2_d = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pm1_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pm1_q     <= pm1_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: vector table of frames plus hand-written
// sequences for busy-ignore, back-to-back and mid-frame reset.
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd1;
  logic       TX_OUT;
  logic       Busy;

  int total  = 0;
  int passed = 0;
  logic last_cap [0:11];

  uart_tx_frame #(.DATA_WIDTH(8), .CNT_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
    logic [5:0] pre;
    logic       exp_par;
    int         exp_len1;   // frame length with a single stop bit
  } vec_t;

  vec_t vecs [0:7];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic idle_run(input int n, input string name);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) bad++;
      step();
    end
    check(name, bad, 0);
  endtask

  // Issues one request and follows the frame until Busy falls.
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic [5:0] pre, input logic exp_par, input int exp_len1,
                           input bit hold, input bit disturb, input string name);
    logic model [0:11];
    int   p, nb, len, k, bad;
    logic exp_tx;
    p  = (pre == 0) ? 1 : int'(pre);
    model[0] = 1'b0;
    for (int i = 0; i < 8; i++) model[1+i] = d[i];
    nb = 9;
    if (pen) begin
      model[nb] = (^d) ^ ptyp;
      nb++;
    end
    for (int i = 0; i < STOP_BITS; i++) begin
      model[nb] = 1'b1;
      nb++;
    end
    len = nb * p;
    for (int i = 0; i < 12; i++) last_cap[i] = 1'bx;

    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = pre; Data_Valid = 1'b1;
    step();
    if (!hold) Data_Valid = 1'b0;
    k = 0; bad = 0;
    while (Busy === 1'b1 && k < 3000) begin
      exp_tx = (k < len) ? model[k / p] : 1'b1;
      if (k >= len || TX_OUT !== exp_tx) bad++;
      if ((k % p) == (p / 2) && (k / p) < 12) last_cap[k / p] = TX_OUT;
      if (disturb && k == 5) begin
        Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = ~pen; PAR_TYP = ~ptyp; Prescale = pre + 6'd3;
      end
      if (disturb && k == 6) Data_Valid = 1'b0;
      step();
      k++;
    end
    check({name, " wave"}, bad, 0);
    check({name, " busy_len"}, k, exp_len1 + (STOP_BITS - 1) * p);
    check({name, " end_idle"}, {TX_OUT, Busy}, 2'b10);
    if (pen) check({name, " parity"}, last_cap[9], exp_par);
  endtask

  initial begin
    logic [9:0] got_bits;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  1'b0, 80};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 176};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd16, 1'b1, 176};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 6'd3,  1'b0, 30};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 6'd1,  1'b1, 11};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 6'd0,  1'b0, 11};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 6'd63, 1'b1, 693};
    vecs[7] = '{8'h55, 1'b0, 1'b1, 6'd2,  1'b0, 20};

    // Reset held for three cycles, then a long quiet idle.
    RST = 1'b1;
    repeat (3) step();
    check("reset_state", {TX_OUT, Busy}, 2'b10);
    RST = 1'b0;
    idle_run(100, "idle_100");

    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].data, vecs[v].pen, vecs[v].ptyp, vecs[v].pre,
                vecs[v].exp_par, vecs[v].exp_len1, 1'b0, 1'b0, $sformatf("vec%0d", v));
      if (v == 0) begin
        for (int i = 0; i < 10; i++) got_bits[i] = last_cap[i];
        check("a5_bit_sequence", got_bits, 10'h34A);
      end
      idle_run(2, $sformatf("vec%0d gap", v));
    end

    // Request and input changes during a frame are ignored.
    run_frame(8'h3C, 1'b0, 1'b0, 6'd5, 1'b0, 50, 1'b0, 1'b1, "busy_ignore");
    idle_run(40, "no_second_frame");
    PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // Data_Valid held high: exactly one idle cycle between frames.
    run_frame(8'h01, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b1, 1'b0, "b2b_first");
    run_frame(8'h80, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b0, 1'b0, "b2b_second");
    idle_run(10, "b2b_after");

    // Reset in the middle of data bit 3 of 0xA5 (bit value 0).
    P_DATA = 8'hA5; PAR_EN = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    repeat (17) step();
    check("mid_rst before", {TX_OUT, Busy}, 2'b01);
    RST = 1'b1;
    step();
    check("mid_rst after", {TX_OUT, Busy}, 2'b10);
    RST = 1'b0;
    run_frame(8'h55, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b0, 1'b0, "post_rst_55");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
